fwd_prop_engine: RTL and testbench
==================================

FWD_PROP_ENGINE -- requirements
Module: fwd_prop_engine

Interface
REQ-001 SHALL have parameter N_IN, default 15: input-vector length.
REQ-002 SHALL have parameter N_HID, default 10: hidden neurons.
REQ-003 SHALL have parameter N_OUT, default 10: output neurons.
REQ-004 SHALL have parameter DATA_W, default 16: signed fixed-point width of weights, inputs and activations.
REQ-005 SHALL have parameter FRAC_W, default 8: fractional bits.
REQ-006 SHALL have parameter ACC_W, default 40: signed accumulator width.
REQ-007 SHALL have parameters HID_ACT, default 1, and OUT_ACT, default 2: activation code for each layer (0 linear, 1 ReLU, 2 hard sigmoid).
REQ-008 SHALL have local parameter W_AW = clog2(N_HID*(N_IN+1) + N_OUT*(N_HID+1)).
REQ-009 SHALL use one clock; reset is synchronous and active-high. Ports follow in REQ-010 to REQ-021.
REQ-010 clk  in  1  rising-edge clock.
REQ-011 rst  in  1  synchronous active-high reset.
REQ-012 start  in  1  one-cycle request to run one inference.
REQ-013 busy  out  1  high from the cycle after start is accepted until done.
REQ-014 done  out  1  one-cycle pulse when the last output has been written.
REQ-015 w_addr  out  W_AW  weight-memory read address.
REQ-016 w_data  in  DATA_W  weight-memory data, valid 1 cycle after w_addr.
REQ-017 x_addr  out  clog2(N_IN)  input-vector read address.
REQ-018 x_data  in  DATA_W  input-vector data, valid 1 cycle after x_addr.
REQ-019 out_valid  out  1  out_data is valid this cycle.
REQ-020 out_idx  out  clog2(N_OUT)  index of the output neuron.
REQ-021 out_data  out  DATA_W  activated output value.

Function
REQ-022 SHALL lay out weight memory per neuron as fan-in weights followed by one bias word. The layer-0 neuron n base is n*(N_IN+1). The layer-1 neuron m base is N_HID*(N_IN+1) + m*(N_HID+1).
REQ-023 SHALL use FSM states IDLE, HID, OUT and FIN. Transitions: IDLE->HID on start; HID->OUT after the last hidden neuron; OUT->FIN after the last output neuron; FIN->IDLE after one cycle, with done=1 in FIN.
REQ-024 SHALL process each neuron with fan-in F in F+3 cycles:
- cycles 0..F: issue address c (c=F is the bias);
- cycles 1..F+1: accumulate;
- cycle F+2: activate and write.
REQ-025 SHALL add each product w*x, sign-extended to ACC_W, to the accumulator. SHALL add the bias as bias<<<FRAC_W. SHALL clear the accumulator at cycle 0 of each neuron.
REQ-026 SHALL activate by arithmetic-shifting the accumulator right by FRAC_W (truncate toward -inf) and saturating to the signed DATA_W range. SHALL then apply the activation function.
REQ-027 SHALL implement ReLU as max(v,0).
REQ-028 SHALL implement hard sigmoid as clamp((v>>>2) + 2^(FRAC_W-1), 0, 2^FRAC_W).
REQ-029 SHALL store hidden results in an internal N_HID-entry buffer. The output layer SHALL read this buffer (combinational read, aligned to the w_data latency) instead of x_data.
REQ-030 SHALL pulse out_valid for exactly one cycle per output neuron, at cycle F+2, with out_idx ascending 0..N_OUT-1.
REQ-031 SHALL make the total latency from the start-accept edge to the done pulse equal to N_HID*(N_IN+3) + N_OUT*(N_HID+3) + 1 cycles.
REQ-032 SHALL ignore start while busy.
REQ-033 SHALL hold w_addr, x_addr and out_data at their last values when idle. out_valid SHALL be 0 outside write cycles.

Reset
REQ-034 SHALL, on rst=1 at any clock edge including mid-inference, go to IDLE. busy, done, out_valid, out_idx, out_data, w_addr, x_addr and the accumulator SHALL all be 0.
REQ-035 SHALL not clear the hidden buffer on reset; it is always rewritten before the output layer reads it.
REQ-036 SHALL give rst priority over a start asserted in the same cycle.

Structure
REQ-037 SHALL place in a shared package fwd_prop_pkg:
- the activation codes (ACT_LIN, ACT_RELU, ACT_HSIG);
- the FSM state type;
- the default Q-format constants.
REQ-038 SHALL implement the shift, saturate and activation stage as one combinational sub-module, fp_activation, parameterised by DATA_W, FRAC_W, ACC_W and mode, and instantiated once with the mode chosen per layer.

Verification
Scenarios use N_IN=2, N_HID=2, N_OUT=1, FRAC_W=8, HID_ACT=ReLU, OUT_ACT=linear unless stated.
REQ-039 Basic run: all weights 256, biases 0, inputs 256 -> hidden values 512; out_data=1024 with out_idx=0; done exactly 16 cycles after the start edge.
REQ-040 Saturation and ReLU: weights 32767, inputs 32767 -> out_data=32767. Negating the layer-0 weights -> hidden values 0 and out_data=0.
REQ-041 Hard sigmoid, OUT_ACT=2: output-layer weights 0, bias 0 -> out_data=128. Bias 2048 -> out_data=256. Bias -2048 -> out_data=0.
REQ-042 start pulsed again at cycle 5 of a run -> ignored; done pulses once; a second start after done gives an identical result.
REQ-043 rst asserted at cycle 7 -> next cycle busy=0, out_valid=0, all outputs 0. A new start then gives the REQ-039 result.

Source files
------------

// File: rtl/fwd_prop_pkg.sv
// Shared codes, state type and Q-format defaults
// for the forward-propagation engine.
package fwd_prop_pkg;

  typedef logic [1:0] act_t;

  localparam act_t ACT_LIN  = 2'd0;
  localparam act_t ACT_RELU = 2'd1;
  localparam act_t ACT_HSIG = 2'd2;

  typedef logic [1:0] fsm_t;

  localparam fsm_t S_IDLE = 2'd0;
  localparam fsm_t S_HID  = 2'd1;
  localparam fsm_t S_OUT  = 2'd2;
  localparam fsm_t S_FIN  = 2'd3;

  localparam int Q_DATA_W = 16;
  localparam int Q_FRAC_W = 8;
  localparam int Q_ACC_W  = 40;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fwd_prop_engine_act.sv
// Combinational shift, saturate and activation stage
// shared by both layers.
module fp_activation
  import fwd_prop_pkg::*;
#(
  parameter int DATA_W = Q_DATA_W,
  parameter int FRAC_W = Q_FRAC_W,
  parameter int ACC_W  = Q_ACC_W
) (
  input  act_t                     mode,
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] res
);

  localparam logic signed [DATA_W-1:0] V_MAX =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] V_MIN =
    {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W:0] HALF =
    (DATA_W+1)'(1 << (FRAC_W-1));
  localparam logic signed [DATA_W:0] ONE =
    (DATA_W+1)'(1 << FRAC_W);

  logic signed [ACC_W-1:0]  sh;
  logic signed [DATA_W-1:0] v;
  logic signed [DATA_W:0]   hs;
  logic                     ovf;

  always_comb begin
    sh  = acc >>> FRAC_W;
    // Out of range when the bits above the result sign disagree.
    ovf = (sh[ACC_W-1:DATA_W-1] !=
           {(ACC_W-DATA_W+1){sh[ACC_W-1]}});
    v   = sh[DATA_W-1:0];
    if (ovf) v = sh[ACC_W-1] ? V_MIN : V_MAX;
    hs  = ($signed({v[DATA_W-1], v}) >>> 2) + HALF;
    res = v;
    unique case (1'b1)
      (mode == ACT_RELU): res = v[DATA_W-1] ? '0 : v;
      (mode == ACT_HSIG): begin
        if (hs[DATA_W])  res = '0;
        else if (hs > ONE) res = ONE[DATA_W-1:0];
        else             res = hs[DATA_W-1:0];
      end
      default: res = v;
    endcase
  end

endmodule

// File: rtl/fwd_prop_engine.sv
// Two-layer fully connected inference engine, one
// multiply-accumulate per cycle from external memories.
module fwd_prop_engine
  import fwd_prop_pkg::*;
#(
  parameter int N_IN    = 15,
  parameter int N_HID   = 10,
  parameter int N_OUT   = 10,
  parameter int DATA_W  = Q_DATA_W,
  parameter int FRAC_W  = Q_FRAC_W,
  parameter int ACC_W   = Q_ACC_W,
  parameter int HID_ACT = 1,
  parameter int OUT_ACT = 2,
  localparam int W_AW =
    idx_w(N_HID*(N_IN+1) + N_OUT*(N_HID+1)),
  localparam int X_AW = idx_w(N_IN),
  localparam int O_IW = idx_w(N_OUT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [W_AW-1:0]          w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  output logic [X_AW-1:0]          x_addr,
  input  logic signed [DATA_W-1:0] x_data,
  output logic                     out_valid,
  output logic [O_IW-1:0]          out_idx,
  output logic signed [DATA_W-1:0] out_data
);

  localparam int CW =
    $clog2(((N_IN > N_HID) ? N_IN : N_HID) + 3);
  localparam int NW =
    idx_w((N_HID > N_OUT) ? N_HID : N_OUT);
  localparam int HW = idx_w(N_HID);
  localparam int L1_BASE = N_HID*(N_IN+1);

  localparam logic [CW-1:0] HID_END  = CW'(N_IN+2);
  localparam logic [CW-1:0] OUT_END  = CW'(N_HID+2);
  localparam logic [NW-1:0] HID_LAST = NW'(N_HID-1);
  localparam logic [NW-1:0] OUT_LAST = NW'(N_OUT-1);

  fsm_t st;
  fsm_t st_n;

  logic [NW-1:0] nrn;
  logic [NW-1:0] nrn_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [CW-1:0] cm1;
  logic [CW-1:0] fan;
  logic [CW-1:0] fan_n;

  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0]   xv;
  logic signed [DATA_W-1:0]   act;
  logic signed [DATA_W-1:0]   hbuf [N_HID];

  act_t mode;
  logic in_hid;
  logic in_out;
  logic issue;
  int   a_n;

  always_comb begin
    st_n  = st;
    nrn_n = nrn;
    cnt_n = cnt;
    unique case (st)
      S_IDLE: begin
        if (start) begin
          st_n  = S_HID;
          nrn_n = '0;
          cnt_n = '0;
        end
      end
      S_HID: begin
        if (cnt == HID_END) begin
          cnt_n = '0;
          if (nrn == HID_LAST) begin
            st_n  = S_OUT;
            nrn_n = '0;
          end else begin
            nrn_n = nrn + NW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_OUT: begin
        if (cnt == OUT_END) begin
          cnt_n = '0;
          if (nrn == OUT_LAST) begin
            st_n  = S_FIN;
            nrn_n = '0;
          end else begin
            nrn_n = nrn + NW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_FIN: st_n = S_IDLE;
    endcase
  end

  // Addresses are registered one cycle ahead of use.
  always_comb begin
    in_hid = (st_n == S_HID);
    in_out = (st_n == S_OUT);
    fan_n  = in_hid ? CW'(N_IN) : CW'(N_HID);
    issue  = (in_hid || in_out) && (cnt_n <= fan_n);
    if (in_hid)
      a_n = int'(nrn_n)*(N_IN+1) + int'(cnt_n);
    else
      a_n = L1_BASE + int'(nrn_n)*(N_HID+1)
          + int'(cnt_n);
  end

  // Operand for cycle c belongs to the address issued at c-1.
  always_comb begin
    cm1 = cnt - CW'(1);
    fan = (st == S_HID) ? CW'(N_IN) : CW'(N_HID);
    xv  = x_data;
    if (st == S_OUT) begin
      xv = '0;
      if (cm1 < CW'(N_HID)) xv = hbuf[cm1[HW-1:0]];
    end
    prod = (2*DATA_W)'(w_data) * (2*DATA_W)'(xv);
    mode = (st == S_OUT) ? act_t'(OUT_ACT)
                         : act_t'(HID_ACT);
  end

  assign prod_ext =
    {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_ext =
    {{(ACC_W-DATA_W-FRAC_W){w_data[DATA_W-1]}},
     w_data, {FRAC_W{1'b0}}};

  fp_activation #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_act (
    .mode (mode),
    .acc  (acc),
    .res  (act)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_IDLE;
      nrn       <= '0;
      cnt       <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      w_addr    <= '0;
      x_addr    <= '0;
    end else begin
      st        <= st_n;
      nrn       <= nrn_n;
      cnt       <= cnt_n;
      busy      <= (st_n != S_IDLE);
      done      <= (st == S_FIN);
      out_valid <= 1'b0;
      if (issue) w_addr <= W_AW'(a_n);
      if (issue && in_hid && (cnt_n < CW'(N_IN)))
        x_addr <= X_AW'(cnt_n);
      if (st == S_HID || st == S_OUT) begin
        if (cnt == '0) begin
          acc <= '0;
        end else if (cnt == fan + CW'(1)) begin
          acc <= acc + bias_ext;
        end else if (cnt <= fan) begin
          acc <= acc + prod_ext;
        end else if (st == S_OUT) begin
          out_valid <= 1'b1;
          out_idx   <= O_IW'(nrn);
          out_data  <= act;
        end
      end
    end
  end

  // Hidden results are always rewritten before being read.
  always_ff @(posedge clk) begin
    if (!rst && st == S_HID && cnt == HID_END)
      hbuf[nrn[HW-1:0]] <= act;
  end

endmodule

// File: tb/tb_fwd_prop_engine.sv
// Directed bench: linear and hard-sigmoid output variants
// checked cycle by cycle against a layer-level model.
`timescale 1ns/1ps
module tb_fwd_prop_engine;

  localparam int NI  = 2;
  localparam int NH  = 2;
  localparam int NO  = 1;
  localparam int FW  = 8;
  localparam int NWT = NH*(NI+1) + NO*(NH+1);
  localparam int LAT = NH*(NI+3) + NO*(NH+3) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;

  logic busy0, done0, ov0;
  logic busy1, done1, ov1;
  logic [3:0] wa0, wa1;
  logic [0:0] xa0, xa1;
  logic [0:0] oi0, oi1;
  logic signed [15:0] wd0, wd1, xd0, xd1, od0, od1;

  logic signed [15:0] wmem [NWT];
  logic signed [15:0] xmem [NI];

  fwd_prop_engine #(
    .N_IN(NI), .N_HID(NH), .N_OUT(NO),
    .DATA_W(16), .FRAC_W(FW), .ACC_W(40),
    .HID_ACT(1), .OUT_ACT(0)
  ) u0 (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy0), .done(done0),
    .w_addr(wa0), .w_data(wd0),
    .x_addr(xa0), .x_data(xd0),
    .out_valid(ov0), .out_idx(oi0), .out_data(od0)
  );

  fwd_prop_engine #(
    .N_IN(NI), .N_HID(NH), .N_OUT(NO),
    .DATA_W(16), .FRAC_W(FW), .ACC_W(40),
    .HID_ACT(1), .OUT_ACT(2)
  ) u1 (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy1), .done(done1),
    .w_addr(wa1), .w_data(wd1),
    .x_addr(xa1), .x_data(xd1),
    .out_valid(ov1), .out_idx(oi1), .out_data(od1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    wd0 <= (int'(wa0) < NWT) ? wmem[wa0] : 16'sd0;
    wd1 <= (int'(wa1) < NWT) ? wmem[wa1] : 16'sd0;
    xd0 <= xmem[xa0];
    xd1 <= xmem[xa1];
  end

  function automatic longint act_f(input longint acc,
                                   input int mode);
    longint v;
    v = acc >>> FW;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    if (mode == 1 && v < 0) v = 0;
    if (mode == 2) begin
      v = (v >>> 2) + 128;
      if (v < 0) v = 0;
      if (v > 256) v = 256;
    end
    return v;
  endfunction

  function automatic longint model_out(input int m,
                                       input int oact);
    longint h [NH];
    longint acc;
    int b;
    for (int n = 0; n < NH; n++) begin
      b = n*(NI+1);
      acc = longint'(wmem[b+NI]) * 256;
      for (int i = 0; i < NI; i++)
        acc += longint'(wmem[b+i]) * longint'(xmem[i]);
      h[n] = act_f(acc, 1);
    end
    b = NH*(NI+1) + m*(NH+1);
    acc = longint'(wmem[b+NH]) * 256;
    for (int j = 0; j < NH; j++)
      acc += longint'(wmem[b+j]) * h[j];
    return act_f(acc, oact);
  endfunction

  function automatic int wr_off(input int m);
    return NH*(NI+3) + (m+1)*(NH+3);
  endfunction

  int cyc = 0;
  int t0 = 0;
  int rst_cyc = -10;
  bit run = 0;
  bit chk_en = 0;
  longint exp0 [NO];
  longint exp1 [NO];
  longint last0 = 0;
  longint last1 = 0;
  int lidx = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      run = 0;
      rst_cyc = cyc;
      last0 = 0;
      last1 = 0;
      lidx = 0;
      chk_en = 1;
    end else begin
      if (start && (!run || cyc >= t0 + LAT + 1)) begin
        run = 1;
        t0 = cyc;
        for (int m = 0; m < NO; m++) begin
          exp0[m] = model_out(m, 0);
          exp1[m] = model_out(m, 2);
        end
      end
      if (run)
        for (int m = 0; m < NO; m++)
          if (cyc == t0 + wr_off(m)) begin
            last0 = exp0[m];
            last1 = exp1[m];
            lidx = m;
          end
    end
  end

  int vecs = 0;
  int errs = 0;
  int ndone = 0;
  longint cap0 = 0;
  longint cap1 = 0;

  task automatic chk(input string nm, input longint got,
                     input longint exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    int k;
    bit eb, ed, ev;
    if (chk_en) begin
      k = cyc - t0;
      eb = run && k >= 0 && k < LAT;
      ed = run && k == LAT;
      ev = 0;
      for (int m = 0; m < NO; m++)
        if (run && k == wr_off(m)) ev = 1;
      chk("busy0", longint'(busy0), longint'(eb));
      chk("busy1", longint'(busy1), longint'(eb));
      chk("done0", longint'(done0), longint'(ed));
      chk("done1", longint'(done1), longint'(ed));
      chk("out_valid0", longint'(ov0), longint'(ev));
      chk("out_valid1", longint'(ov1), longint'(ev));
      chk("out_data0", od0, last0);
      chk("out_data1", od1, last1);
      chk("out_idx0", longint'(oi0), lidx);
      chk("out_idx1", longint'(oi1), lidx);
      if (cyc == rst_cyc) begin
        chk("rst_w_addr0", longint'(wa0), 0);
        chk("rst_x_addr0", longint'(xa0), 0);
        chk("rst_w_addr1", longint'(wa1), 0);
        chk("rst_x_addr1", longint'(xa1), 0);
      end
      if (ov0) cap0 = od0;
      if (ov1) cap1 = od1;
      if (done0) ndone++;
    end
  end

  int tacc = 0;

  task automatic load(input int w0, input int b0,
                      input int w1, input int b1,
                      input int x);
    for (int n = 0; n < NH; n++) begin
      for (int i = 0; i < NI; i++)
        wmem[n*(NI+1)+i] = 16'(w0);
      wmem[n*(NI+1)+NI] = 16'(b0);
    end
    for (int m = 0; m < NO; m++) begin
      for (int j = 0; j < NH; j++)
        wmem[NH*(NI+1)+m*(NH+1)+j] = 16'(w1);
      wmem[NH*(NI+1)+m*(NH+1)+NH] = 16'(b1);
    end
    for (int i = 0; i < NI; i++) xmem[i] = 16'(x);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    tacc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int n = 0;
    while (!done0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - tacc;
    if (!done0) begin
      vecs++;
      errs++;
      $display("FAIL done_timeout: no done after %0d cycles", n);
    end
    @(negedge clk);
  endtask

  task automatic scen(input string nm, input longint e0,
                      input longint e1, input int retrig);
    int lat;
    cap0 = -99999;
    cap1 = -99999;
    pulse_start();
    if (retrig > 0) begin
      repeat (retrig - 1) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(lat);
    chk({nm, "_lat"}, lat, LAT);
    chk({nm, "_lin"}, cap0, e0);
    chk({nm, "_hsig"}, cap1, e1);
    chk({nm, "_model_lin"}, model_out(0, 0), e0);
    chk({nm, "_model_hsig"}, model_out(0, 2), e1);
  endtask

  initial begin
    int nd;
    longint first;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    longint first;
    load(256, 0, 256, 0, 256);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    scen("basic", 1024, 256, 0);
    chk("idle_w_addr", longint'(wa0), 8);
    chk("idle_x_addr", longint'(xa0), 1);
    chk("lat_formula", LAT, 16);

    load(32767, 0, 32767, 0, 32767);
    scen("sat", 32767, 256, 0);
    load(-32767, 0, 32767, 0, 32767);
    scen("relu", 0, 128, 0);

    load(256, 0, 0, 0, 256);
    scen("hs_zero", 0, 128, 0);
    load(256, 0, 0, 2048, 256);
    scen("hs_pos", 2048, 256, 0);
    load(256, 0, 0, -2048, 256);
    scen("hs_neg", -2048, 0, 0);

    load(256, 0, 256, 0, 256);
    nd = ndone;
    scen("retrig", 1024, 256, 5);
    first = cap0;
    repeat (5) @(negedge clk);
    chk("done_once", ndone - nd, 1);
    scen("again", 1024, 256, 0);
    chk("repeat_same", cap0, first);

    pulse_start();
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", longint'(busy0), 0);
    chk("mid_rst_valid", longint'(ov0), 0);
    chk("mid_rst_data", od0, 0);
    chk("mid_rst_w_addr", longint'(wa0), 0);
    scen("after_rst", 1024, 256, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
